// File: rtl/hist_pkg.sv
// hist_pkg: shared FSM states, drain length and bin extraction for the histogram engine
package hist_pkg;
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_COPY, S_DONE} state_t;
  localparam int DRAIN_CYCLES = 2;
  function automatic logic [31:0] bin_of(input logic [31:0] pixel, input int pixel_w, input int bin_bits);
    return (pixel >> (pixel_w - bin_bits)) & ((32'd1 << bin_bits) - 32'd1);
  endfunction
endpackage

// File: rtl/dp_bram.sv
// dp_bram: simple dual-port RAM with one write port and one registered read port (read-before-write)
module dp_bram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // a read to the address being written on the same edge returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/histogram_engine_bin_updater.sv
// hist_bin_updater: 2-stage read-modify-write bin counter with forwarding; HIST_SATURATE_EN selects saturate vs wrap
module hist_bin_updater #(
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic [BIN_BITS-1:0] pix_bin,
  output logic [BIN_BITS-1:0] rd_addr,
  input  logic [COUNT_W-1:0]  rd_data,
  output logic                wr_en,
  output logic [BIN_BITS-1:0] wr_addr,
  output logic [COUNT_W-1:0]  wr_data
);
  logic                s1_valid;
  logic [BIN_BITS-1:0] s1_bin;
  logic                w_valid;
  logic [BIN_BITS-1:0] w_bin;
  logic [COUNT_W-1:0]  w_val;
  logic [COUNT_W-1:0]  base;
  assign rd_addr = pix_bin;
  assign wr_en   = s1_valid;
  assign wr_addr = s1_bin;
  // the bank read raced last cycle's write, so a matching bin takes the retired value instead
  always_comb begin
    base = (w_valid && w_bin == s1_bin) ? w_val : rd_data;
`ifdef HIST_SATURATE_EN
    wr_data = &base ? base : base + COUNT_W'(1);
`else
    wr_data = base + COUNT_W'(1);
`endif
  end
  // stage 1 tracks the bin beside the bank read; the retired write is kept one cycle for forwarding
  always_ff @(posedge clk) begin
    s1_valid <= rst ? 1'b0 : pix_valid;
    s1_bin   <= pix_bin;
    w_valid  <= rst ? 1'b0 : s1_valid;
    w_bin    <= s1_bin;
    w_val    <= wr_data;
  end
endmodule

// File: rtl/histogram_engine.sv
// histogram_engine: framed pixel histogram with clear/copy sweeps and a host result bank; HIST_SATURATE_EN selects saturating bins
module histogram_engine
  import hist_pkg::*;
#(
  parameter int PIXEL_W  = 8,
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                calc_flag,
  input  logic [PIXEL_W-1:0]  in_pixel,
  input  logic                in_valid,
  input  logic                end_of_frame,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [COUNT_W-1:0]  rd_data,
  output logic                out_valid,
  output logic                busy,
  output logic                dropped
);
  localparam int BINS = 2 ** BIN_BITS;
  state_t              state, nxt;
  logic [BIN_BITS-1:0] cnt;
  logic [BIN_BITS-1:0] pix_bin;
  logic                upd_we;
  logic [BIN_BITS-1:0] upd_raddr, upd_waddr;
  logic [COUNT_W-1:0]  upd_wdata;
  logic                acc_we;
  logic [BIN_BITS-1:0] acc_waddr, acc_raddr;
  logic [COUNT_W-1:0]  acc_wdata, acc_rdata;
  logic                res_we;
  logic [COUNT_W-1:0]  res_rdata;
  logic                rd_zero, rd_byp;
  logic [COUNT_W-1:0]  rd_byp_val;
  assign pix_bin = BIN_BITS'(bin_of(32'(in_pixel), PIXEL_W, BIN_BITS));
  // next state and status outputs
  always_comb begin
    nxt = state;
    case (state)
      S_CLEAR: nxt = &cnt ? S_IDLE : S_CLEAR;
      S_IDLE:  nxt = calc_flag ? S_ACCUM : S_IDLE;
      S_ACCUM: nxt = (in_valid && end_of_frame) ? S_DRAIN : S_ACCUM;
      S_DRAIN: nxt = (cnt == BIN_BITS'(DRAIN_CYCLES - 1)) ? S_COPY : S_DRAIN;
      S_COPY:  nxt = &cnt ? S_DONE : S_COPY;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_CLEAR;
    endcase
    busy      = !(state == S_IDLE || state == S_ACCUM);
    out_valid = state == S_DONE;
  end
  // state register; the sweep counter restarts on every state change
  always_ff @(posedge clk) begin
    state <= rst ? S_CLEAR : nxt;
    cnt   <= (rst || nxt != state) ? '0 : cnt + BIN_BITS'(1);
  end
  // sticky drop flag: a stray pixel outweighs the arm that would clear it
  always_ff @(posedge clk) begin
    dropped <= rst ? 1'b0 :
               (in_valid && state != S_ACCUM) ? 1'b1 :
               (state == S_IDLE && calc_flag) ? 1'b0 : dropped;
  end
  // bank port steering; copy prefetches bin cnt+1 so bin cnt is in hand when it is published and zeroed
  always_comb begin
    acc_we    = upd_we || state == S_CLEAR || state == S_COPY;
    acc_waddr = upd_we ? upd_waddr : cnt;
    acc_wdata = upd_we ? upd_wdata : '0;
    acc_raddr = state == S_ACCUM ? upd_raddr : state == S_COPY ? cnt + BIN_BITS'(1) : '0;
    res_we    = state == S_COPY && !rst;
    rd_data   = rd_zero ? '0 : rd_byp ? rd_byp_val : res_rdata;
  end
  // host read path: bypass the word being published on the same edge so DONE already sees the last bin
  always_ff @(posedge clk) begin
    rd_zero    <= rst;
    rd_byp     <= res_we && cnt == rd_addr;
    rd_byp_val <= acc_rdata;
  end
  hist_bin_updater #(.BIN_BITS(BIN_BITS), .COUNT_W(COUNT_W)) u_upd (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (state == S_ACCUM && in_valid),
    .pix_bin   (pix_bin),
    .rd_addr   (upd_raddr),
    .rd_data   (acc_rdata),
    .wr_en     (upd_we),
    .wr_addr   (upd_waddr),
    .wr_data   (upd_wdata)
  );
  dp_bram #(.DEPTH(BINS), .WIDTH(COUNT_W)) u_acc (
    .clk   (clk),
    .we    (acc_we),
    .waddr (acc_waddr),
    .wdata (acc_wdata),
    .raddr (acc_raddr),
    .rdata (acc_rdata)
  );
  dp_bram #(.DEPTH(BINS), .WIDTH(COUNT_W)) u_res (
    .clk   (clk),
    .we    (res_we),
    .waddr (cnt),
    .wdata (acc_rdata),
    .raddr (rd_addr),
    .rdata (res_rdata)
  );
endmodule

// File: tb/tb_histogram_engine.sv
// tb_histogram_engine: directed self-checking bench for histogram_engine
module tb_histogram_engine;
  localparam int BINS = 256;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calc_flag = 1'b0, in_valid = 1'b0, end_of_frame = 1'b0;
  logic [7:0]  in_pixel = '0, rd_addr = '0;
  logic [15:0] rd_data;
  logic        out_valid, busy, dropped;
  logic        s_calc = 1'b0, s_valid = 1'b0, s_eof = 1'b0;
  logic [7:0]  s_pixel = '0;
  logic [3:0]  s_rd_addr = '0;
  logic [3:0]  s_rd_data;
  logic        s_out_valid, s_busy, s_dropped;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  histogram_engine u_dut (
    .clk(clk), .rst(rst), .calc_flag(calc_flag), .in_pixel(in_pixel), .in_valid(in_valid),
    .end_of_frame(end_of_frame), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .busy(busy), .dropped(dropped)
  );

  histogram_engine #(.PIXEL_W(8), .BIN_BITS(4), .COUNT_W(4)) u_small (
    .clk(clk), .rst(rst), .calc_flag(s_calc), .in_pixel(s_pixel), .in_valid(s_valid),
    .end_of_frame(s_eof), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .out_valid(s_out_valid), .busy(s_busy), .dropped(s_dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    calc_flag = 1'b1;
    tick();
    calc_flag = 1'b0;
  endtask

  task automatic send(input logic [7:0] p, input logic e);
    in_pixel = p;
    in_valid = 1'b1;
    end_of_frame = e;
    tick();
    in_valid = 1'b0;
    end_of_frame = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] p, input logic e);
    s_pixel = p;
    s_valid = 1'b1;
    s_eof = e;
    tick();
    s_valid = 1'b0;
    s_eof = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(out_valid), 1);
  endtask

  task automatic read_bin(input logic [7:0] a, output logic [15:0] v);
    rd_addr = a;
    tick();
    v = rd_data;
  endtask

  task automatic s_read(input logic [3:0] a, output logic [3:0] v);
    s_rd_addr = a;
    tick();
    v = s_rd_data;
  endtask

  task automatic scan(input logic [7:0] hot, input logic [15:0] hot_cnt, input logic [15:0] rest, output int bad);
    logic [15:0] v;
    bad = 0;
    for (int i = 0; i < BINS; i++) begin
      read_bin(8'(i), v);
      if (v !== ((8'(i) == hot) ? hot_cnt : rest)) bad++;
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  sv;
    logic [7:0]  sp [4];
    int          bad, nov, n;
    sp = '{8'h00, 8'h0F, 8'h10, 8'hFF};
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_dropped", 32'(dropped), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    repeat (BINS - 1) tick();
    check("clear_busy_last", 32'(busy), 1);
    tick();
    check("clear_to_idle", 32'(busy), 0);

    arm();
    for (int i = 0; i < BINS; i++) send(8'(i), i == BINS - 1);
    repeat (BINS + 1) tick();
    check("f1_ov_early", 32'(out_valid), 0);
    rd_addr = 8'hFF;
    tick();
    check("f1_ov_at_e259", 32'(out_valid), 1);
    check("f1_bin255_at_ov", 32'(rd_data), 1);
    tick();
    check("f1_ov_pulse", 32'(out_valid), 0);
    scan(8'h00, 16'd1, 16'd1, bad);
    check("f1_all_bins_one", 32'(bad), 0);

    arm();
    for (int i = 0; i < 100; i++) send(8'h37, i == 99);
    wait_ov("f2_ov");
    read_bin(8'h37, v);
    check("f2_bin37", 32'(v), 100);
    scan(8'h37, 16'd100, 16'd0, bad);
    check("f2_all_bins", 32'(bad), 0);

    arm();
    for (int i = 0; i < 100; i++) send(8'h37, i == 99);
    wait_ov("f3_ov");
    read_bin(8'h37, v);
    check("f3_bin37_cleared", 32'(v), 100);
    scan(8'h37, 16'd100, 16'd0, bad);
    check("f3_all_bins", 32'(bad), 0);

    send(8'h10, 1'b0);
    check("drop_idle", 32'(dropped), 1);
    arm();
    check("drop_clear_on_arm", 32'(dropped), 0);
    for (int i = 0; i < 3; i++) send(8'h20, i == 2);
    repeat (10) tick();
    check("f4_in_copy", 32'(busy), 1);
    send(8'h30, 1'b0);
    check("drop_copy", 32'(dropped), 1);
    wait_ov("f4_ov");
    read_bin(8'h10, v);
    check("f4_idle_pixel_uncounted", 32'(v), 0);
    read_bin(8'h20, v);
    check("f4_bin20", 32'(v), 3);
    read_bin(8'h30, v);
    check("f4_copy_pixel_uncounted", 32'(v), 0);
    check("drop_sticky", 32'(dropped), 1);

    arm();
    check("drop_clear_f5", 32'(dropped), 0);
    for (int i = 0; i < 5; i++) send(8'hA0, i == 4);
    repeat (22) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    nov = 0;
    for (int i = 0; i < BINS; i++) begin
      if (busy !== 1'b1) bad++;
      if (out_valid !== 1'b0) nov++;
      if (i < BINS - 1) tick();
    end
    check("rst2_busy_hold", 32'(bad), 0);
    check("rst2_no_ov", 32'(nov), 0);
    tick();
    check("rst2_idle", 32'(busy), 0);
    read_bin(8'h20, v);
    check("rst2_keep_bin20", 32'(v), 3);
    read_bin(8'hA0, v);
    check("rst2_keep_binA0", 32'(v), 0);

    arm();
    for (int i = 0; i < 2; i++) send(8'hA0, i == 1);
    wait_ov("f6_ov");
    read_bin(8'hA0, v);
    check("f6_binA0_fresh", 32'(v), 2);
    read_bin(8'h20, v);
    check("f6_bin20", 32'(v), 0);

    s_calc = 1'b1;
    tick();
    s_calc = 1'b0;
    for (int i = 0; i < 4; i++) s_send(sp[i], 1'b0);
    for (int i = 0; i < 20; i++) s_send(8'h55, i == 19);
    n = 0;
    while (s_out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("small_ov", 32'(s_out_valid), 1);
    s_read(4'd0, sv);
    check("small_bin0", 32'(sv), 2);
    s_read(4'd1, sv);
    check("small_bin1", 32'(sv), 1);
    s_read(4'd15, sv);
    check("small_bin15", 32'(sv), 1);
    s_read(4'd5, sv);
`ifdef HIST_SATURATE_EN
    check("small_bin5_sat", 32'(sv), 15);
`else
    check("small_bin5_wrap", 32'(sv), 4);
`endif
    s_read(4'd7, sv);
    check("small_bin7", 32'(sv), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
